// File: rtl/noc_input_port_ctrl_if.sv
// Flit format shared by the router input port, plus the buffer/allocator/crossbar
// bundle seen by the input-port controller.
package noc_pkg;
  localparam int x_Des_Addr_Size = 4;
  localparam int y_Des_Addr_Size = 4;
  localparam int PAYLOAD_W       = 22;
  localparam int FLIT_W          = 2 + x_Des_Addr_Size + y_Des_Addr_Size + PAYLOAD_W;

  typedef enum logic [1:0] {
    LBL_BODY     = 2'b00,
    LBL_HEAD     = 2'b01,
    LBL_TAIL     = 2'b10,
    LBL_HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t                label;
    logic [x_Des_Addr_Size-1:0] x_dest;
    logic [y_Des_Addr_Size-1:0] y_dest;
    logic [PAYLOAD_W-1:0]       payload;
  } flit_Data_noVC;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_ACTIVE     = 2'd2
  } port_state_t;

  // One-hot output port vector, bit order {LOCAL,NORTH,SOUTH,EAST,WEST}.
  localparam logic [4:0] ROUTE_LOCAL = 5'b10000;
  localparam logic [4:0] ROUTE_NORTH = 5'b01000;
  localparam logic [4:0] ROUTE_SOUTH = 5'b00100;
  localparam logic [4:0] ROUTE_EAST  = 5'b00010;
  localparam logic [4:0] ROUTE_WEST  = 5'b00001;
endpackage

// Handshakes: buffer pops on a rising edge where buf_read_o=1 (only when
// buf_empty_i=0); a flit is transferred to the crossbar on any cycle with
// xb_valid_o=1 (only when out_stop_i=0); sa_grant_i is sampled while sa_req_o=1.
interface noc_input_port_ctrl_if;
  import noc_pkg::*;

  flit_Data_noVC buf_data_i;
  logic          buf_empty_i;
  logic          buf_read_o;
  logic          sa_req_o;
  logic [4:0]    route_o;
  logic          sa_grant_i;
  logic          out_stop_i;
  flit_Data_noVC xb_flit_o;
  logic          xb_valid_o;

  modport master (
    input  buf_data_i, buf_empty_i, sa_grant_i, out_stop_i,
    output buf_read_o, sa_req_o, route_o, xb_flit_o, xb_valid_o
  );

  modport slave (
    output buf_data_i, buf_empty_i, sa_grant_i, out_stop_i,
    input  buf_read_o, sa_req_o, route_o, xb_flit_o, xb_valid_o
  );
endinterface

// File: rtl/noc_input_port_ctrl.sv
// Router input-port controller: XY-routes the head flit, holds the switch
// allocator request for the whole packet and streams flits to the crossbar.
module noc_input_port_ctrl
  import noc_pkg::*;
#(
  parameter logic [x_Des_Addr_Size-1:0] X_CUR = '0,
  parameter logic [y_Des_Addr_Size-1:0] Y_CUR = '0,
  parameter int                         CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_input_port_ctrl_if.master ip,
  output logic                 err_o,
  output logic [CNT_W-1:0]     pkt_cnt_o,
  output logic [CNT_W-1:0]     flit_cnt_o,
  output port_state_t          dbg_state_o
);

  port_state_t      state_q, state_d;
  logic [4:0]       route_q, route_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_cnt_q, flit_cnt_q;
  logic             pop, send, is_head, is_tail;
  flit_Data_noVC    head_flit;

  function automatic logic [4:0] xy_route(input flit_Data_noVC f);
    if (f.x_dest > X_CUR)      return ROUTE_EAST;
    else if (f.x_dest < X_CUR) return ROUTE_WEST;
    else if (f.y_dest > Y_CUR) return ROUTE_NORTH;
    else if (f.y_dest < Y_CUR) return ROUTE_SOUTH;
    else                       return ROUTE_LOCAL;
  endfunction

  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    err_d     = 1'b0;
    pop       = 1'b0;
    send      = 1'b0;
    head_flit = ip.buf_data_i;
    is_head   = (head_flit.label == LBL_HEAD) || (head_flit.label == LBL_HEADTAIL);
    is_tail   = (head_flit.label == LBL_TAIL) || (head_flit.label == LBL_HEADTAIL);

    case (state_q)
      ST_IDLE: begin
        if (!ip.buf_empty_i) begin
          if (is_head) begin
            route_d = xy_route(head_flit);
            state_d = ST_WAIT_GRANT;
          end else begin
            // Orphan BODY/TAIL (e.g. left over from a reset mid-packet) is dropped.
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT_GRANT: begin
        if (ip.sa_grant_i) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        send = !ip.buf_empty_i && !ip.out_stop_i;
        pop  = send;
        if (send && is_tail) begin
          state_d = ST_IDLE;
          route_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        route_d = '0;
      end
    endcase

    // While reset is held the port neither pops nor drives the crossbar.
    if (rst) begin
      pop  = 1'b0;
      send = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      route_q    <= '0;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      err_q   <= err_d;
      if (send && flit_cnt_q != '1)
        flit_cnt_q <= flit_cnt_q + CNT_W'(1);
      if (send && is_tail && pkt_cnt_q != '1)
        pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
    end
  end

  assign ip.buf_read_o = pop;
  assign ip.xb_valid_o = send;
  assign ip.xb_flit_o  = (state_q == ST_ACTIVE && !rst) ? ip.buf_data_i : '0;
  assign ip.sa_req_o   = (state_q != ST_IDLE) && !rst;
  assign ip.route_o    = route_q;
  assign err_o         = err_q;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign flit_cnt_o    = flit_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_noc_input_port_ctrl.sv
// Bench for noc_input_port_ctrl: directed packet sequences on a (1,1) router plus
// a table of XY-route vectors on a (2,2) router with narrow saturating counters.
module tb_noc_input_port_ctrl;
  import noc_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  noc_input_port_ctrl_if a_if ();
  noc_input_port_ctrl_if b_if ();

  logic        a_err, b_err;
  logic [15:0] a_pkt, a_flit;
  logic [1:0]  b_pkt, b_flit;
  port_state_t a_state, b_state;

  noc_input_port_ctrl #(.X_CUR(4'd1), .Y_CUR(4'd1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ip(a_if), .err_o(a_err),
    .pkt_cnt_o(a_pkt), .flit_cnt_o(a_flit), .dbg_state_o(a_state)
  );

  noc_input_port_ctrl #(.X_CUR(4'd2), .Y_CUR(4'd2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .ip(b_if), .err_o(b_err),
    .pkt_cnt_o(b_pkt), .flit_cnt_o(b_flit), .dbg_state_o(b_state)
  );

  logic [FLIT_W-1:0] buf_q[$];
  logic [FLIT_W-1:0] exp_q[$];
  logic              bubble;
  int                n_checks, n_pass;
  int                req_cycles, valid_cycles;
  int                seq;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] route;
  } route_vec_t;
  route_vec_t rt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [FLIT_W-1:0] mk(input flit_label_t l, input int x, input int y);
    flit_Data_noVC f;
    f.label   = l;
    f.x_dest  = 4'(x);
    f.y_dest  = 4'(y);
    f.payload = 22'(seq);
    seq++;
    return f;
  endfunction

  // One clock cycle: present buffer head at negedge, sample the port, pop at posedge.
  task automatic step();
    logic rd, v;
    logic [FLIT_W-1:0] f, e;
    @(negedge clk);
    a_if.buf_empty_i = bubble || (buf_q.size() == 0);
    a_if.buf_data_i  = (buf_q.size() == 0) ? '0 : flit_Data_noVC'(buf_q[0]);
    #1;
    rd = a_if.buf_read_o;
    v  = a_if.xb_valid_o;
    f  = a_if.xb_flit_o;
    if (a_if.sa_req_o) req_cycles++;
    if (a_if.buf_empty_i) check("no_pop_when_empty", 32'(rd), 32'(0));
    if (v) begin
      valid_cycles++;
      if (exp_q.size() == 0) check("xb_unexpected_flit", f, 32'hdead_beef);
      else begin
        e = exp_q.pop_front();
        check("xb_flit_order", f, e);
      end
    end
    @(posedge clk);
    if (rd && buf_q.size() != 0) void'(buf_q.pop_front());
    #2;
  endtask

  task automatic check_a_quiet(input string tag);
    check({tag, "_buf_read"}, 32'(a_if.buf_read_o), 32'(0));
    check({tag, "_sa_req"},   32'(a_if.sa_req_o),   32'(0));
    check({tag, "_route"},    32'(a_if.route_o),    32'(0));
    check({tag, "_xb_valid"}, 32'(a_if.xb_valid_o), 32'(0));
    check({tag, "_xb_flit"},  a_if.xb_flit_o,       32'(0));
    check({tag, "_err"},      32'(a_err),           32'(0));
    check({tag, "_pkt_cnt"},  32'(a_pkt),           32'(0));
    check({tag, "_flit_cnt"}, 32'(a_flit),          32'(0));
    check({tag, "_state"},    32'(a_state),         32'(ST_IDLE));
  endtask

  initial begin
    logic [FLIT_W-1:0] f;
    n_checks = 0; n_pass = 0; seq = 1; bubble = 1'b0;
    rt[0] = '{x: 4'd0, y: 4'd5, route: 5'b00001};
    rt[1] = '{x: 4'd2, y: 4'd5, route: 5'b01000};
    rt[2] = '{x: 4'd2, y: 4'd0, route: 5'b00100};
    rt[3] = '{x: 4'd5, y: 4'd0, route: 5'b00010};
    rt[4] = '{x: 4'd2, y: 4'd2, route: 5'b10000};
    rt[5] = '{x: 4'd1, y: 4'd9, route: 5'b00001};

    a_if.sa_grant_i = 1'b0; a_if.out_stop_i = 1'b0;
    a_if.buf_empty_i = 1'b1; a_if.buf_data_i = '0;
    b_if.sa_grant_i = 1'b0; b_if.out_stop_i = 1'b0;
    b_if.buf_empty_i = 1'b1; b_if.buf_data_i = '0;

    // Reset state
    rst = 1'b1;
    step(); step();
    check_a_quiet("reset");
    rst = 1'b0;

    // 4-flit packet to (3,1) from (1,1): EAST
    req_cycles = 0; valid_cycles = 0;
    f = mk(LBL_HEAD, 3, 1); buf_q.push_back(f); exp_q.push_back(f);
    f = mk(LBL_BODY, 3, 1); buf_q.push_back(f); exp_q.push_back(f);
    f = mk(LBL_BODY, 3, 1); buf_q.push_back(f); exp_q.push_back(f);
    f = mk(LBL_TAIL, 3, 1); buf_q.push_back(f); exp_q.push_back(f);
    step();
    check("p1_route_east", 32'(a_if.route_o), 32'(5'b00010));
    check("p1_state_wait", 32'(a_state), 32'(ST_WAIT_GRANT));
    check("p1_head_not_popped", buf_q.size(), 4);
    a_if.sa_grant_i = 1'b1;
    step();
    a_if.sa_grant_i = 1'b0;
    check("p1_state_active", 32'(a_state), 32'(ST_ACTIVE));
    for (int i = 0; i < 4; i++) step();
    check("p1_req_cycles", req_cycles, 5);
    check("p1_valid_pulses", valid_cycles, 4);
    check("p1_sa_req_dropped", 32'(a_if.sa_req_o), 32'(0));
    check("p1_route_cleared", 32'(a_if.route_o), 32'(0));
    check("p1_pkt_cnt", 32'(a_pkt), 32'(1));
    check("p1_flit_cnt", 32'(a_flit), 32'(4));
    check("p1_all_delivered", exp_q.size(), 0);

    // HEADTAIL to own coordinates: LOCAL, one send cycle
    f = mk(LBL_HEADTAIL, 1, 1); buf_q.push_back(f); exp_q.push_back(f);
    step();
    check("p2_route_local", 32'(a_if.route_o), 32'(5'b10000));
    a_if.sa_grant_i = 1'b1;
    step();
    a_if.sa_grant_i = 1'b0;
    check("p2_xb_valid_first_active", 32'(a_if.xb_valid_o), 32'(1));
    step();
    check("p2_state_idle", 32'(a_state), 32'(ST_IDLE));
    check("p2_sa_req_dropped", 32'(a_if.sa_req_o), 32'(0));
    check("p2_pkt_cnt", 32'(a_pkt), 32'(2));
    check("p2_flit_cnt", 32'(a_flit), 32'(5));

    // Route table on the (2,2) router; its 2-bit counters saturate at 3
    for (int i = 0; i < 6; i++) begin
      b_if.buf_data_i  = flit_Data_noVC'(mk(LBL_HEADTAIL, int'(rt[i].x), int'(rt[i].y)));
      b_if.buf_empty_i = 1'b0;
      step();
      check($sformatf("rt%0d_route", i), 32'(b_if.route_o), 32'(rt[i].route));
      b_if.sa_grant_i = 1'b1;
      step();
      b_if.sa_grant_i = 1'b0;
      check($sformatf("rt%0d_send", i), 32'(b_if.buf_read_o & b_if.xb_valid_o), 32'(1));
      step();
      b_if.buf_empty_i = 1'b1;
      check($sformatf("rt%0d_idle", i), 32'(b_state), 32'(ST_IDLE));
      check($sformatf("rt%0d_pkt_sat", i), 32'(b_pkt), (i + 1 > 3) ? 32'(3) : 32'(i + 1));
    end
    check("rt_flit_sat", 32'(b_flit), 32'(3));

    // 3 flits (WEST) with 3 stalled cycles then a 2-cycle bubble mid-packet
    f = mk(LBL_HEAD, 0, 1); buf_q.push_back(f); exp_q.push_back(f);
    f = mk(LBL_BODY, 0, 1); buf_q.push_back(f); exp_q.push_back(f);
    f = mk(LBL_TAIL, 0, 1); buf_q.push_back(f); exp_q.push_back(f);
    step();
    check("p3_route_west", 32'(a_if.route_o), 32'(5'b00001));
    a_if.sa_grant_i = 1'b1; a_if.out_stop_i = 1'b1;
    step();
    a_if.sa_grant_i = 1'b0;
    valid_cycles = 0;
    for (int i = 0; i < 3; i++) step();
    check("p3_stall_no_pop", buf_q.size(), 3);
    check("p3_stall_no_valid", valid_cycles, 0);
    a_if.out_stop_i = 1'b0;
    step();
    bubble = 1'b1;
    step(); step();
    check("p3_bubble_no_pop", buf_q.size(), 2);
    check("p3_bubble_flit_cnt", 32'(a_flit), 32'(6));
    bubble = 1'b0;
    step(); step();
    check("p3_state_idle", 32'(a_state), 32'(ST_IDLE));
    check("p3_valid_total", valid_cycles, 3);
    check("p3_all_delivered", exp_q.size(), 0);
    check("p3_pkt_cnt", 32'(a_pkt), 32'(3));

    // Orphan BODY in IDLE, then a normal HEADTAIL (NORTH)
    buf_q.push_back(mk(LBL_BODY, 1, 2));
    f = mk(LBL_HEADTAIL, 1, 2); buf_q.push_back(f); exp_q.push_back(f);
    step();
    check("p4_err_pulse", 32'(a_err), 32'(1));
    check("p4_body_popped", buf_q.size(), 1);
    check("p4_state_idle", 32'(a_state), 32'(ST_IDLE));
    step();
    check("p4_err_one_cycle", 32'(a_err), 32'(0));
    check("p4_route_north", 32'(a_if.route_o), 32'(5'b01000));
    a_if.sa_grant_i = 1'b1;
    step();
    a_if.sa_grant_i = 1'b0;
    step();
    check("p4_pkt_cnt", 32'(a_pkt), 32'(4));
    check("p4_flit_cnt", 32'(a_flit), 32'(9));
    check("p4_all_delivered", exp_q.size(), 0);

    // Reset after the 2nd flit of a 4-flit packet
    f = mk(LBL_HEAD, 2, 1); buf_q.push_back(f); exp_q.push_back(f);
    f = mk(LBL_BODY, 2, 1); buf_q.push_back(f); exp_q.push_back(f);
    buf_q.push_back(mk(LBL_BODY, 2, 1));
    buf_q.push_back(mk(LBL_TAIL, 2, 1));
    step();
    a_if.sa_grant_i = 1'b1;
    step();
    a_if.sa_grant_i = 1'b0;
    step(); step();
    check("p5_two_sent", exp_q.size(), 0);
    rst = 1'b1;
    step();
    check_a_quiet("p5_reset");
    check("p5_reset_no_pop", buf_q.size(), 2);
    rst = 1'b0;
    step();
    check("p5_body_err", 32'(a_err), 32'(1));
    check("p5_body_dropped", buf_q.size(), 1);
    step();
    check("p5_tail_err", 32'(a_err), 32'(1));
    check("p5_tail_dropped", buf_q.size(), 0);
    step();
    check("p5_err_clear", 32'(a_err), 32'(0));
    check("p5_state_idle", 32'(a_state), 32'(ST_IDLE));
    check("p5_pkt_cnt", 32'(a_pkt), 32'(0));
    check("p5_flit_cnt", 32'(a_flit), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
